// File: rtl/bscan_pkg.sv
// Shared definitions for the boundary-scan output chain.
//   mode_e      : pad source select (NORMAL, EXTEST, CLAMP, HIGHZ)
//   data_idx/oe_idx : chain positions of a channel's data and output-enable cells
package bscan_pkg;

   typedef enum logic [1:0] {
      MODE_NORMAL = 2'd0,
      MODE_EXTEST = 2'd1,
      MODE_CLAMP  = 2'd2,
      MODE_HIGHZ  = 2'd3
   } mode_e;

   localparam int unsigned CELLS_PER_CH = 2;
   localparam int unsigned DATA_OFS     = 0;
   localparam int unsigned OE_OFS       = 1;

   function automatic int unsigned data_idx(input int unsigned ch);
      return CELLS_PER_CH * ch + DATA_OFS;
   endfunction

   function automatic int unsigned oe_idx(input int unsigned ch);
      return CELLS_PER_CH * ch + OE_OFS;
   endfunction

endpackage

// File: rtl/bscan_if.sv
// Scan-control bundle between the TAP-side controller and the DR chain.
//   capture_dr, shift_dr, update_dr : DR phase controls
//   tdi : serial scan in, tdo : serial scan out
// master = TAP side, slave = chain side.
interface bscan_if;

   logic capture_dr;
   logic shift_dr;
   logic update_dr;
   logic tdi;
   logic tdo;

   modport master (
      output capture_dr,
      output shift_dr,
      output update_dr,
      output tdi,
      input  tdo
   );

   modport slave (
      input  capture_dr,
      input  shift_dr,
      input  update_dr,
      input  tdi,
      output tdo
   );

endinterface

// File: rtl/bscan_cell.sv
// One boundary-scan cell: capture/shift stage plus update stage.
//   clk, rst_n     : scan clock, async active-low reset
//   capture_dr     : load shift stage from cap_in (wins over shift_dr)
//   shift_dr       : load shift stage from si
//   update_dr      : copy pre-edge shift stage into update stage
//   cap_in, si     : capture source, serial in
//   so, uq         : shift stage out, update stage out
// RST_VAL is the reset value of the update stage only; the shift stage resets to 0.
module bscan_cell #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic capture_dr,
   input  logic shift_dr,
   input  logic update_dr,
   input  logic cap_in,
   input  logic si,
   output logic so,
   output logic uq
);

   logic sr_q, sr_d;
   logic upd_q, upd_d;

   always_comb begin
      sr_d = sr_q;
      if (capture_dr) begin
         sr_d = cap_in;
      end else if (shift_dr) begin
         sr_d = si;
      end
   end

   always_comb begin
      upd_d = upd_q;
      if (update_dr) begin
         upd_d = sr_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr_q  <= 1'b0;
         upd_q <= RST_VAL;
      end else begin
         sr_q  <= sr_d;
         upd_q <= upd_d;
      end
   end

   assign so = sr_q;
   assign uq = upd_q;

endmodule

// File: rtl/bscan_out_chain.sv
// Boundary-scan output register for NCH tristate pad channels.
//   clk, rst_n      : scan clock, async active-low reset
//   core_d, core_oe : functional data / enable from the core
//   pad_i           : pad readback, captured into the data cells
//   mode            : pad source select (see bscan_pkg::mode_e)
//   scan            : DR controls, tdi/tdo
//   pad_o, pad_oe   : to pad drivers
//   upd_q           : update-stage contents (cell 2i data, 2i+1 OE)
// The chain runs tdi -> cell L-1 -> ... -> cell 0 -> tdo.
module bscan_out_chain
   import bscan_pkg::*;
#(
   parameter int unsigned NCH    = 8,
   parameter logic        RST_OE = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NCH-1:0]    core_d,
   input  logic [NCH-1:0]    core_oe,
   input  logic [NCH-1:0]    pad_i,
   input  mode_e             mode,
   bscan_if.slave            scan,
   output logic [NCH-1:0]    pad_o,
   output logic [NCH-1:0]    pad_oe,
   output logic [2*NCH-1:0]  upd_q
);

   localparam int unsigned L = 2 * NCH;

   logic [L-1:0] so_vec;
   logic [L-1:0] si_vec;

   // Each cell takes its serial input from the next-higher cell; the top cell takes tdi.
   assign si_vec   = {scan.tdi, so_vec[L-1:1]};
   assign scan.tdo = so_vec[0];

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      localparam int unsigned DI = data_idx(i);
      localparam int unsigned OI = oe_idx(i);

      logic po, poe;

      bscan_cell #(
         .RST_VAL (1'b0)
      ) u_data (
         .clk        (clk),
         .rst_n      (rst_n),
         .capture_dr (scan.capture_dr),
         .shift_dr   (scan.shift_dr),
         .update_dr  (scan.update_dr),
         .cap_in     (pad_i[i]),
         .si         (si_vec[DI]),
         .so         (so_vec[DI]),
         .uq         (upd_q[DI])
      );

      bscan_cell #(
         .RST_VAL (RST_OE)
      ) u_oe (
         .clk        (clk),
         .rst_n      (rst_n),
         .capture_dr (scan.capture_dr),
         .shift_dr   (scan.shift_dr),
         .update_dr  (scan.update_dr),
         .cap_in     (core_oe[i]),
         .si         (si_vec[OI]),
         .so         (so_vec[OI]),
         .uq         (upd_q[OI])
      );

      // Mode is deliberately not registered: outputs follow it combinationally.
      always_comb begin
         po  = upd_q[DI];
         poe = 1'b0;
         unique case (mode)
            MODE_NORMAL: begin
               po  = core_d[i];
               poe = core_oe[i];
            end
            MODE_EXTEST: poe = upd_q[OI];
            MODE_CLAMP:  poe = 1'b1;
            MODE_HIGHZ:  poe = 1'b0;
            default:     poe = 1'b0;
         endcase
      end

      assign pad_o[i]  = po;
      assign pad_oe[i] = poe;
   end

endmodule

// File: tb/tb_bscan_out_chain.sv
// Self-checking bench for bscan_out_chain (NCH=4) against a vector-level model.
module tb_bscan_out_chain;
   import bscan_pkg::*;

   localparam int unsigned NCH    = 4;
   localparam int unsigned L      = 2 * NCH;
   localparam logic        RST_OE = 1'b0;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [NCH-1:0] core_d, core_oe, pad_i;
   logic [NCH-1:0] pad_o, pad_oe;
   logic [L-1:0]   upd_q;
   mode_e          mode;

   bscan_if scan ();

   always #5 clk = ~clk;

   bscan_out_chain #(
      .NCH    (NCH),
      .RST_OE (RST_OE)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .core_d  (core_d),
      .core_oe (core_oe),
      .pad_i   (pad_i),
      .mode    (mode),
      .scan    (scan),
      .pad_o   (pad_o),
      .pad_oe  (pad_oe),
      .upd_q   (upd_q)
   );

   // Reference state: shift register and update register as whole vectors.
   logic [L-1:0] m_sr, m_upd;
   int unsigned  n_cmp = 0;
   int unsigned  n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_sr = '0;
      for (int i = 0; i < NCH; i++) begin
         m_upd[2*i]   = 1'b0;
         m_upd[2*i+1] = RST_OE;
      end
   endtask

   function automatic logic [NCH-1:0] exp_pad_o();
      logic [NCH-1:0] r;
      for (int i = 0; i < NCH; i++) r[i] = (mode == MODE_NORMAL) ? core_d[i] : m_upd[2*i];
      return r;
   endfunction

   function automatic logic [NCH-1:0] exp_pad_oe();
      logic [NCH-1:0] r;
      for (int i = 0; i < NCH; i++) begin
         case (mode)
            MODE_NORMAL: r[i] = core_oe[i];
            MODE_EXTEST: r[i] = m_upd[2*i+1];
            MODE_CLAMP:  r[i] = 1'b1;
            default:     r[i] = 1'b0;
         endcase
      end
      return r;
   endfunction

   task automatic check_all(input string tag);
      check({tag, ".tdo"},    32'(scan.tdo), 32'(m_sr[0]));
      check({tag, ".upd_q"},  32'(upd_q),    32'(m_upd));
      check({tag, ".pad_o"},  32'(pad_o),    32'(exp_pad_o()));
      check({tag, ".pad_oe"}, 32'(pad_oe),   32'(exp_pad_oe()));
   endtask

   // One clock edge with the given controls; model advances using pre-edge values.
   task automatic step(input logic cap, input logic sh, input logic up, input logic t);
      logic [L-1:0] prev, nxt;
      scan.capture_dr = cap;
      scan.shift_dr   = sh;
      scan.update_dr  = up;
      scan.tdi        = t;
      @(posedge clk);
      prev = m_sr;
      nxt  = prev;
      if (cap) begin
         for (int i = 0; i < NCH; i++) begin
            nxt[2*i]   = pad_i[i];
            nxt[2*i+1] = core_oe[i];
         end
      end else if (sh) begin
         nxt = {t, prev[L-1:1]};
      end
      if (up) m_upd = prev;
      m_sr = nxt;
      #1;
      scan.capture_dr = 1'b0;
      scan.shift_dr   = 1'b0;
      scan.update_dr  = 1'b0;
      scan.tdi        = 1'b0;
   endtask

   task automatic shift_in(input logic [L-1:0] v);
      for (int j = 0; j < L; j++) step(1'b0, 1'b1, 1'b0, v[j]);
   endtask

   initial begin
      logic [L-1:0] prior;
      rst_n           = 1'b0;
      mode            = MODE_EXTEST;
      core_d          = '0;
      core_oe         = '0;
      pad_i           = '0;
      scan.capture_dr = 1'b0;
      scan.shift_dr   = 1'b0;
      scan.update_dr  = 1'b0;
      scan.tdi        = 1'b0;
      model_reset();
      #2;
      check("rst.upd_q", 32'(upd_q), 32'h00);
      check("rst.pad_oe", 32'(pad_oe), 32'h0);
      check("rst.tdo", 32'(scan.tdo), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // NORMAL pass-through, no scan activity
      mode    = MODE_NORMAL;
      core_d  = 4'hA;
      core_oe = 4'h5;
      #1;
      check("norm.pad_o", 32'(pad_o), 32'hA);
      check("norm.pad_oe", 32'(pad_oe), 32'h5);

      // Shift 8'hCA LSB-first, update, EXTEST
      shift_in(8'hCA);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      mode = MODE_EXTEST;
      #1;
      check("ext.upd_q", 32'(upd_q), 32'hCA);
      check("ext.pad_o", 32'(pad_o), 32'b1000);
      check("ext.pad_oe", 32'(pad_oe), 32'b1011);
      check_all("ext");

      // Capture then shift out, watching tdo bit by bit
      pad_i   = 4'h6;
      core_oe = 4'h9;
      step(1'b1, 1'b0, 1'b0, 1'b0);
      check("cap.sr0", 32'(scan.tdo), 32'h0);
      check_all("cap");
      for (int j = 0; j < L; j++) begin
         step(1'b0, 1'b1, 1'b0, 1'b0);
         check("capshift", 32'(scan.tdo), 32'(m_sr[0]));
      end

      // Capture + shift + update on one edge
      shift_in(8'h3C);
      pad_i   = 4'h3;
      core_oe = 4'hC;
      prior   = m_sr;
      step(1'b1, 1'b1, 1'b1, 1'b1);
      check("cs.upd_prior", 32'(upd_q), 32'(prior));
      check_all("cs");
      for (int j = 0; j < L; j++) begin
         step(1'b0, 1'b1, 1'b0, 1'b0);
         check("cs.unload", 32'(scan.tdo), 32'(m_sr[0]));
      end

      // Forced modes with upd all ones
      shift_in(8'hFF);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      mode = MODE_CLAMP;
      #1;
      check("clamp.pad_oe", 32'(pad_oe), 32'hF);
      check("clamp.pad_o", 32'(pad_o), 32'hF);
      mode = MODE_HIGHZ;
      #1;
      check("highz.pad_oe", 32'(pad_oe), 32'h0);
      check_all("highz");

      // Reset asserted mid-shift
      step(1'b0, 1'b1, 1'b0, 1'b1);
      scan.shift_dr  = 1'b1;
      scan.update_dr = 1'b1;
      scan.tdi       = 1'b1;
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("mrst.upd_q", 32'(upd_q), 32'h00);
      check("mrst.tdo", 32'(scan.tdo), 32'h0);
      @(posedge clk);
      #1;
      check("mrst.hold_upd", 32'(upd_q), 32'h00);
      check_all("mrst");
      @(negedge clk);
      rst_n          = 1'b1;
      scan.shift_dr  = 1'b0;
      scan.update_dr = 1'b0;
      scan.tdi       = 1'b0;

      // Randomised traffic
      for (int n = 0; n < 400; n++) begin
         core_d  = NCH'($urandom);
         core_oe = NCH'($urandom);
         pad_i   = NCH'($urandom);
         mode    = mode_e'($urandom_range(0, 3));
         #1;
         check_all("rnd.comb");
         step(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 5) == 0), 1'($urandom));
         check_all("rnd.seq");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
